param_register_file: RTL

- Parametrised successor to the 16x32 three-port register file used by the datapath.
- Configurable data width and register count; three combinational read ports; two synchronous write ports (ALU result and load/base-writeback).
- Dedicated PC register in the highest index, loaded from the PC input under its own enable.
- Synchronous reset and defined write-priority rules on address collisions.

---
 rtl/param_register_file.sv | 99 +++++++++
 1 files changed

// File: rtl/param_register_file.sv
// Parametrised register file: three combinational read ports, two write ports, PC in top register.
// Optional read forwarding of next-edge values when PARAM_REGFILE_BYPASS_EN is defined.

module param_register_file_lane #(
  parameter int             WIDTH = 32,
  parameter int             AW    = 4,
  parameter logic [AW-1:0]  IDX   = '0,
  parameter bit             IS_PC = 1'b0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [AW-1:0]    RW0,
  input  logic [WIDTH-1:0] PW0,
  input  logic             LE0,
  input  logic [AW-1:0]    RW1,
  input  logic [WIDTH-1:0] PW1,
  input  logic             LE1,
  input  logic [WIDTH-1:0] PC,
  input  logic             PC_LE,
  output logic [WIDTH-1:0] d_o
);
  logic sel0, sel1, selpc;

  // Enables gate the address compare so X on an idle port never selects data.
  assign sel0  = LE0 && (RW0 == IDX);
  assign sel1  = LE1 && (RW1 == IDX);
  assign selpc = IS_PC && PC_LE;

  always_comb begin
    d_o = q_i;
    if (sel0)       d_o = PW0;
    else if (sel1)  d_o = PW1;
    else if (selpc) d_o = PC;
  end
endmodule

module param_register_file #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [AW-1:0]    RD,
  output logic [WIDTH-1:0] PA,
  output logic [WIDTH-1:0] PB,
  output logic [WIDTH-1:0] PD,
  input  logic [AW-1:0]    RW0,
  input  logic [WIDTH-1:0] PW0,
  input  logic             LE0,
  input  logic [AW-1:0]    RW1,
  input  logic [WIDTH-1:0] PW1,
  input  logic             LE1,
  input  logic [WIDTH-1:0] PC,
  input  logic             PC_LE
);
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d, rd_data;

  if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("param_register_file: NREGS must be a power of two and >= 4");
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_lane
    param_register_file_lane #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .IDX   (AW'(i)),
      .IS_PC (i == NREGS - 1)
    ) u_lane (
      .q_i   (regs_q[i]),
      .RW0   (RW0),
      .PW0   (PW0),
      .LE0   (LE0),
      .RW1   (RW1),
      .PW1   (PW1),
      .LE1   (LE1),
      .PC    (PC),
      .PC_LE (PC_LE),
      .d_o   (regs_d[i])
    );
  end

  always_ff @(posedge Clk) begin
    if (Rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

`ifdef PARAM_REGFILE_BYPASS_EN
  // Next-state equals stored value for untouched registers, so forwarding is a whole-array select.
  assign rd_data = Rst ? regs_q : regs_d;
`else
  assign rd_data = regs_q;
`endif

  assign PA = rd_data[RA];
  assign PB = rd_data[RB];
  assign PD = rd_data[RD];
endmodule
